// File: rtl/core_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg                                                             |
// | Shared word width, data-memory latency and responder state encoding. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_pkg;

    localparam int WORD_W       = 32;
    localparam int DMEM_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/sram_1rw.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_1rw                                                             |
// | Single-port synchronous word array with registered read data.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sram_1rw
    import core_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_rdata;

    // Array contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sram_1rw
`default_nettype wire

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_responder                                                   |
// | Fixed-latency data-memory target for the core's request/Ready port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module data_mem_responder
    import core_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
            $error("data_mem_responder: LATENCY must be within 1..15");
        end
    endgenerate

    dmem_state_t       r_state, w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_we, r_mis, r_ready, r_busy, r_err;
    logic [ADDR_W-1:0] r_idx;
    logic [WORD_W-1:0] r_wdata;

    logic              w_accept, w_commit;
    logic              w_src_we, w_src_mis;
    logic [ADDR_W-1:0] w_src_idx;
    logic [WORD_W-1:0] w_src_wdata;
    logic              w_mem_we, w_mem_re;
    logic              w_unused_addr_hi;

    assign w_unused_addr_hi = ^addr[WORD_W-1:ADDR_W+2];

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                    w_commit    = 1'b1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // With a single-cycle latency the commit edge is the accepting edge,
    // so the access has to come straight from the ports.
    assign w_src_we    = (r_state == ST_IDLE) ? we                 : r_we;
    assign w_src_mis   = (r_state == ST_IDLE) ? (addr[1:0] != 2'b00) : r_mis;
    assign w_src_idx   = (r_state == ST_IDLE) ? addr[ADDR_W+1:2]   : r_idx;
    assign w_src_wdata = (r_state == ST_IDLE) ? wdata              : r_wdata;

    assign w_mem_we = reset & w_commit &  w_src_we & ~w_src_mis;
    assign w_mem_re = reset & w_commit & ~w_src_we & ~w_src_mis;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_commit;
            r_err   <= w_commit & w_src_mis;
            if (w_accept) begin
                r_cnt  <= C_CNT_INIT;
                r_busy <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                r_cnt  <= r_cnt - 4'd1;
            end else if (r_state == ST_RESP) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= we;
            r_mis   <= (addr[1:0] != 2'b00);
            r_idx   <= addr[ADDR_W+1:2];
            r_wdata <= wdata;
        end
    end

    sram_1rw #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .i_clr   (~reset),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_src_idx),
        .i_wdata (w_src_wdata),
        .o_rdata (rdata)
    );

    assign ready = r_ready;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_responder                                                |
// | Two responders (LATENCY 3 and 1) sharing stimulus, scoreboard-checked.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_data_mem_responder;

    localparam int ADDR_W = 8;
    localparam int N_DUT  = 2;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic              wr_ok;
        logic [31:0]       wdata;
        logic [31:0]       exp_rdata;
        logic              exp_known;
        logic              exp_err;
        int                due;
    } txn_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        reset, req, we;
    logic [31:0]                 addr, wdata;
    logic [N_DUT-1:0][31:0]      rdata;
    logic [N_DUT-1:0]            ready, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, dut, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 3 : 1;

        data_mem_responder #(
            .ADDR_W  (ADDR_W),
            .LATENCY (L)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .req   (req),
            .we    (we),
            .addr  (addr),
            .wdata (wdata),
            .rdata (rdata[g]),
            .ready (ready[g]),
            .busy  (busy[g]),
            .err   (err[g])
        );

        txn_t        q[$];
        logic [31:0] m_mem [256];
        logic        m_vld [256];
        logic [31:0] m_rdata;
        logic        m_rknown;
        int          m_left, n_edge, n_acc, n_rdy;
        logic [31:0] cap_rdata;
        logic        cap_err;

        initial begin
            txn_t t;
            for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
            m_rdata = '0; m_rknown = 1'b1; m_left = 0;
            n_edge = 0; n_acc = 0; n_rdy = 0;
            cap_rdata = '0; cap_err = 1'b0;
            forever begin
                @(posedge clk);
                n_edge++;
                if (!reset) begin
                    q.delete();
                    m_left = 0; m_rdata = '0; m_rknown = 1'b1;
                end else if (m_left > 0) begin
                    m_left--;
                end else if (req) begin
                    t.idx       = addr[ADDR_W+1:2];
                    t.wr_ok     = we && (addr[1:0] == 2'b00);
                    t.wdata     = wdata;
                    t.exp_err   = (addr[1:0] != 2'b00);
                    if (!we && addr[1:0] == 2'b00) begin
                        t.exp_rdata = m_mem[t.idx];
                        t.exp_known = m_vld[t.idx];
                    end else begin
                        t.exp_rdata = m_rdata;
                        t.exp_known = m_rknown;
                    end
                    t.due = n_edge + L - 1;
                    q.push_back(t);
                    m_left = L;
                    n_acc++;
                end

                @(negedge clk);
                if (ready[g]) n_rdy++;
                if (q.size() > 0 && q[0].due == n_edge) begin
                    t = q.pop_front();
                    check("ready_pulse", g, 32'(ready[g]), 32'd1);
                    check("err_resp", g, 32'(err[g]), 32'(t.exp_err));
                    if (t.exp_known) check("rdata_resp", g, rdata[g], t.exp_rdata);
                    if (t.wr_ok) begin
                        m_mem[t.idx] = t.wdata;
                        m_vld[t.idx] = 1'b1;
                    end
                    m_rdata   = t.exp_rdata;
                    m_rknown  = t.exp_known;
                    cap_rdata = rdata[g];
                    cap_err   = err[g];
                end else begin
                    check("ready_idle", g, 32'(ready[g]), 32'd0);
                    check("err_idle", g, 32'(err[g]), 32'd0);
                    if (m_rknown) check("rdata_hold", g, rdata[g], m_rdata);
                end
                check("busy", g, 32'(busy[g]), 32'(m_left > 0));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy != '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", -1, 32'(busy), 32'd0);
    endtask

    task automatic do_access(input vec_t v, input logic [31:0] exp1_rdata);
        int r0, r1;
        r0 = g_dut[0].n_rdy;
        r1 = g_dut[1].n_rdy;
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        req = 1'b0;
        wait_idle();
        check("ready_count", 0, 32'(g_dut[0].n_rdy - r0), 32'd1);
        check("ready_count", 1, 32'(g_dut[1].n_rdy - r1), 32'd1);
        check("tbl_rdata", 0, g_dut[0].cap_rdata, v.exp_rdata);
        check("tbl_err", 0, 32'(g_dut[0].cap_err), 32'(v.exp_err));
        check("tbl_rdata", 1, g_dut[1].cap_rdata, exp1_rdata);
        check("tbl_err", 1, 32'(g_dut[1].cap_err), 32'(v.exp_err));
    endtask

    vec_t vt[10];

    initial begin
        int acc0, acc1, rdy0, rdy1;
        vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vt[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[2] = '{1'b1, 32'h0000_0013, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1};
        vt[3] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[4] = '{1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
        vt[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vt[6] = '{1'b1, 32'h0000_0024, 32'h0BAD_F00D, 32'hA5A5_A5A5, 1'b0};
        vt[7] = '{1'b0, 32'h0000_03F5, 32'h0,         32'hA5A5_A5A5, 1'b1};
        vt[8] = '{1'b0, 32'h0000_0024, 32'h0,         32'h0BAD_F00D, 1'b0};
        vt[9] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};

        // Reset held with a request pending; acceptance must follow release.
        reset = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h1111_1111;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("first_accept_busy", 0, 32'(busy[0]), 32'd1);
        check("first_accept_busy", 1, 32'(busy[1]), 32'd1);
        req = 1'b0;
        wait_idle();

        for (int i = 0; i < 10; i++) do_access(vt[i], vt[i].exp_rdata);

        // Request held high: the responders drop everything presented while busy.
        acc0 = g_dut[0].n_acc; acc1 = g_dut[1].n_acc;
        rdy0 = g_dut[0].n_rdy; rdy1 = g_dut[1].n_rdy;
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 24; i++) begin
            addr = (i % 2 == 1) ? 32'h24 : 32'h10;
            @(negedge clk);
        end
        req = 1'b0;
        wait_idle();
        check("held_rdy_vs_acc", 0, 32'(g_dut[0].n_rdy - rdy0), 32'(g_dut[0].n_acc - acc0));
        check("held_rdy_vs_acc", 1, 32'(g_dut[1].n_rdy - rdy1), 32'(g_dut[1].n_acc - acc1));
        check("held_rdy_count", 0, 32'(g_dut[0].n_rdy - rdy0), 32'd6);
        check("held_rdy_count", 1, 32'(g_dut[1].n_rdy - rdy1), 32'd12);

        // Reset on the commit edge of a LATENCY=3 store: nothing is written.
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h5555_5555;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_ready", 0, 32'(ready[0]), 32'd0);
        check("abort_busy", 0, 32'(busy[0]), 32'd0);
        wait_idle();
        do_access('{1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0}, 32'h5555_5555);

        // Reset coincident with a LATENCY=1 accept-and-commit edge.
        reset = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'h7777_7777;
        @(negedge clk);
        reset = 1'b1; req = 1'b0;
        check("abort_l1_busy", 1, 32'(busy[1]), 32'd0);
        do_access('{1'b0, 32'h24, 32'h0, 32'h0BAD_F00D, 1'b0}, 32'h0BAD_F00D);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_data_mem_responder
`default_nettype wire
